// File: rtl/clk_div_mon_pkg.sv
// Shared types and helpers for the clock-divider monitor.
// Holds the monitor FSM encoding and the phase-length acceptance check.
package clk_div_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        MEASURE = 2'd2
    } mon_state_t;

    // A phase is acceptable when it lies within tol cycles of half the ratio.
    function automatic logic phase_ok(input int unsigned ph,
                                      input int unsigned num_div,
                                      input int unsigned tol);
        int unsigned half;
        half = num_div / 2;
        if (ph >= half)
            return (ph - half) <= tol;
        else
            return (half - ph) <= tol;
    endfunction

endpackage

// File: rtl/clk_div_edge_det.sv
// Edge detector for the observed divided clock; CLK_DIV_MON_SYNC_EN adds a
// 2-flop synchronizer ahead of the sampler so the input may be asynchronous.
module clk_div_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic clk_div_in,
    output logic rise,
    output logic fall
);

    logic sample;
    logic prev;

`ifdef CLK_DIV_MON_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk) begin
        if (rst)
            sync <= 2'b00;
        else
            sync <= {sync[0], clk_div_in};
    end

    assign sample = sync[1];
`else
    assign sample = clk_div_in;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            prev <= 1'b0;
        else
            prev <= sample;
    end

    // Strobes are combinational so the top can register ticks and
    // measurement results on the same edge.
    assign rise = sample & ~prev;
    assign fall = ~sample & prev;

endmodule

// File: rtl/clk_div_monitor.sv
// Checker for an even-ratio clock divider: edge ticks, phase/period
// measurement, lock and sticky error. Optional input synchronizer: CLK_DIV_MON_SYNC_EN.
module clk_div_monitor
    import clk_div_mon_pkg::*;
#(
    parameter int unsigned NUM_DIV  = 6,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned TOL      = 0,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_div_in,
    input  logic             en,
    input  logic             err_clr,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             locked,
    output logic             err
);

    localparam logic [CNT_W-1:0] STUCK_LIM = CNT_W'(2 * NUM_DIV);
    localparam logic [CNT_W-1:0] LOCK_LIM  = CNT_W'(LOCK_CNT);

    mon_state_t       state, state_nxt;
    logic             rise, fall, chg;
    logic             active, measuring, good, bad, stuck, good_rise;
    logic [CNT_W-1:0] ph_cnt, per_cnt, lock_cnt, lock_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    clk_div_edge_det u_edge_det (
        .clk        (clk),
        .rst        (rst),
        .clk_div_in (clk_div_in),
        .rise       (rise),
        .fall       (fall)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = SYNC;
                SYNC:    if (chg) state_nxt = MEASURE;
                MEASURE: if (stuck) state_nxt = SYNC;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Dropping en acts at once, without waiting for the state to reach IDLE.
    always_comb begin
        chg       = rise | fall;
        active    = en && (state != IDLE);
        measuring = en && (state == MEASURE);
        good      = phase_ok(32'(ph_cnt), NUM_DIV, TOL);
        bad       = measuring && chg && !good;
        stuck     = measuring && !chg && (ph_cnt >= STUCK_LIM);
        good_rise = measuring && rise && good;
        lock_inc  = sat_inc(lock_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_tick  <= 1'b0;
            fall_tick  <= 1'b0;
            period_vld <= 1'b0;
            period     <= '0;
            ph_cnt     <= '0;
            per_cnt    <= '0;
            lock_cnt   <= '0;
            locked     <= 1'b0;
            err        <= 1'b0;
        end else begin
            rise_tick  <= rise;
            fall_tick  <= fall;
            period_vld <= good_rise;

            if (!active) begin
                ph_cnt  <= '0;
                per_cnt <= '0;
            end else begin
                ph_cnt  <= chg  ? CNT_W'(1) : sat_inc(ph_cnt);
                per_cnt <= rise ? CNT_W'(1) : sat_inc(per_cnt);
            end

            if (good_rise)
                period <= per_cnt;

            if (!active || bad || stuck) begin
                lock_cnt <= '0;
                locked   <= 1'b0;
            end else if (good_rise) begin
                lock_cnt <= lock_inc;
                if (lock_inc >= LOCK_LIM)
                    locked <= 1'b1;
            end

            // A fresh fault outranks a simultaneous clear.
            err <= (err & ~err_clr) | ((bad | stuck) & locked);
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Randomized bench for clk_div_monitor (default build, CLK_DIV_MON_SYNC_EN undefined)
// with a timestamp-based reference model for TOL=0 and TOL=1 instances.
module tb_clk_div_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_div_in = 1'b0;
    logic       en = 1'b1;
    logic       err_clr = 1'b0;

    logic       rise_tick0, fall_tick0, period_vld0, locked0, err0;
    logic [7:0] period0;
    logic       rise_tick1, fall_tick1, period_vld1, locked1, err1;
    logic [7:0] period1;

    int n_cmp = 0;
    int n_bad = 0;
    int t = 0;

    always #5 clk = ~clk;

    clk_div_monitor #(.NUM_DIV(6), .CNT_W(8), .TOL(0), .LOCK_CNT(4)) dut (
        .clk(clk), .rst(rst), .clk_div_in(clk_div_in), .en(en), .err_clr(err_clr),
        .rise_tick(rise_tick0), .fall_tick(fall_tick0), .period(period0),
        .period_vld(period_vld0), .locked(locked0), .err(err0)
    );

    clk_div_monitor #(.NUM_DIV(6), .CNT_W(8), .TOL(1), .LOCK_CNT(4)) dut_t1 (
        .clk(clk), .rst(rst), .clk_div_in(clk_div_in), .en(en), .err_clr(err_clr),
        .rise_tick(rise_tick1), .fall_tick(fall_tick1), .period(period1),
        .period_vld(period_vld1), .locked(locked1), .err(err1)
    );

    // Reference model: phase and period lengths come from timestamps of the
    // last edge / last rise; mode 0 = idle, 1 = waiting for first edge, 2 = checking.
    typedef struct {
        int mode;
        bit prev;
        int te;
        int tr;
        int lock_n;
        bit locked;
        bit err;
        bit rt;
        bit ft;
        bit pv;
        int period;
    } mdl_t;

    mdl_t m [2];

    function automatic void mstep(int i, int tol);
        bit r, f, e, fault;
        int ph, per, dev;
        if (rst) begin
            m[i].mode = 0; m[i].prev = 0; m[i].te = 0; m[i].tr = 0;
            m[i].lock_n = 0; m[i].locked = 0; m[i].err = 0;
            m[i].rt = 0; m[i].ft = 0; m[i].pv = 0; m[i].period = 0;
            return;
        end
        r = clk_div_in && !m[i].prev;
        f = !clk_div_in && m[i].prev;
        e = r || f;
        m[i].rt = r;
        m[i].ft = f;
        m[i].pv = 0;
        m[i].prev = clk_div_in;
        fault = 0;
        if (!en || m[i].mode == 0) begin
            m[i].mode = en ? 1 : 0;
            m[i].te = t + 1;
            m[i].tr = t + 1;
            m[i].lock_n = 0;
            m[i].locked = 0;
        end else begin
            ph  = (t - m[i].te > 255) ? 255 : t - m[i].te;
            per = (t - m[i].tr > 255) ? 255 : t - m[i].tr;
            if (m[i].mode == 1) begin
                if (e) m[i].mode = 2;
            end else if (e) begin
                dev = (ph > 3) ? ph - 3 : 3 - ph;
                if (dev <= tol) begin
                    if (r) begin
                        m[i].period = per;
                        m[i].pv = 1;
                        if (m[i].lock_n < 255) m[i].lock_n++;
                        if (m[i].lock_n >= 4) m[i].locked = 1;
                    end
                end else begin
                    fault = m[i].locked;
                    m[i].locked = 0;
                    m[i].lock_n = 0;
                end
            end else if (ph >= 12) begin
                fault = m[i].locked;
                m[i].locked = 0;
                m[i].lock_n = 0;
                m[i].mode = 1;
            end
            if (e) m[i].te = t;
            if (r) m[i].tr = t;
        end
        m[i].err = (m[i].err && !err_clr) || fault;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @t=%0d: got %0d expected %0d", tag, t, got, exp);
        end
    endtask

    // One clock: model follows the inputs sampled at this edge, outputs checked 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        t++;
        mstep(0, 0);
        mstep(1, 1);
        #1;
        chk("d0.rise",   32'(rise_tick0),  32'(m[0].rt));
        chk("d0.fall",   32'(fall_tick0),  32'(m[0].ft));
        chk("d0.pvld",   32'(period_vld0), 32'(m[0].pv));
        chk("d0.period", 32'(period0),     32'(m[0].period));
        chk("d0.locked", 32'(locked0),     32'(m[0].locked));
        chk("d0.err",    32'(err0),        32'(m[0].err));
        chk("d1.rise",   32'(rise_tick1),  32'(m[1].rt));
        chk("d1.fall",   32'(fall_tick1),  32'(m[1].ft));
        chk("d1.pvld",   32'(period_vld1), 32'(m[1].pv));
        chk("d1.period", 32'(period1),     32'(m[1].period));
        chk("d1.locked", 32'(locked1),     32'(m[1].locked));
        chk("d1.err",    32'(err1),        32'(m[1].err));
    endtask

    task automatic wv(input logic lvl);
        clk_div_in = lvl;
        cyc();
    endtask

    task automatic per_wave(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            for (int k = 0; k < hi; k++) wv(1'b1);
            for (int k = 0; k < lo; k++) wv(1'b0);
        end
    endtask

    initial begin
        // Reset with en already high
        rst = 1'b1;
        cyc();
        cyc();
        chk("rst.locked", 32'(locked0), 0);
        chk("rst.err",    32'(err0), 0);
        chk("rst.period", 32'(period0), 0);
        rst = 1'b0;

        // Nominal 3/3 divider output: lock and period 6
        per_wave(3, 3, 8);
        chk("nom.locked", 32'(locked0), 1);
        chk("nom.period", 32'(period0), 6);
        chk("nom.err",    32'(err0), 0);

        // One stretched high phase while locked
        per_wave(4, 3, 1);
        chk("str.err",    32'(err0), 1);
        chk("str.locked", 32'(locked0), 0);
        per_wave(3, 3, 5);
        chk("rel.locked", 32'(locked0), 1);
        chk("rel.err",    32'(err0), 1);

        // Clear alone, then clear coinciding with a bad phase
        err_clr = 1'b1;
        wv(1'b1);
        err_clr = 1'b0;
        wv(1'b1);
        wv(1'b1);
        chk("clr.err", 32'(err0), 0);
        for (int k = 0; k < 3; k++) wv(1'b0);
        for (int k = 0; k < 4; k++) wv(1'b1);
        err_clr = 1'b1;
        wv(1'b0);
        chk("clrhit.err", 32'(err0), 1);
        wv(1'b0);
        chk("clrnext.err", 32'(err0), 0);
        err_clr = 1'b0;
        wv(1'b0);

        // Stuck-high input after lock
        per_wave(3, 3, 5);
        chk("pre_stk.locked", 32'(locked0), 1);
        for (int k = 0; k < 16; k++) wv(1'b1);
        chk("stk.err",    32'(err0), 1);
        chk("stk.locked", 32'(locked0), 0);
        err_clr = 1'b1;
        wv(1'b1);
        err_clr = 1'b0;
        per_wave(3, 3, 7);
        chk("stk_rel.locked", 32'(locked0), 1);

        // Drop en mid-period
        wv(1'b1);
        wv(1'b1);
        en = 1'b0;
        wv(1'b1);
        chk("en0.locked", 32'(locked0), 0);
        for (int k = 0; k < 3; k++) wv(1'b0);
        chk("en0.err", 32'(err0), 0);
        en = 1'b1;
        per_wave(3, 3, 6);
        chk("en1.locked", 32'(locked0), 1);

        // Randomized phases, clears and enable drops
        for (int p = 0; p < 120; p++) begin
            int hi, lo;
            hi = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 5)) : 3;
            lo = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 5)) : 3;
            if ($urandom_range(0, 40) == 0) hi = 14;
            for (int k = 0; k < hi + lo; k++) begin
                en      = !((p % 17 == 5) && (k < 2));
                err_clr = ($urandom_range(0, 15) == 0);
                wv(k < hi);
            end
        end
        en = 1'b1;
        err_clr = 1'b0;

        // Reset in the middle of operation
        per_wave(3, 3, 2);
        rst = 1'b1;
        wv(1'b1);
        chk("mrst.rise",   32'(rise_tick0), 0);
        chk("mrst.locked", 32'(locked0), 0);
        chk("mrst.period", 32'(period0), 0);
        chk("mrst.t1err",  32'(err1), 0);
        rst = 1'b0;
        wv(1'b0);

        // 2/4 phases: accepted with TOL=1, rejected with TOL=0
        per_wave(2, 4, 8);
        chk("tol1.locked", 32'(locked1), 1);
        chk("tol1.period", 32'(period1), 6);
        chk("tol1.err",    32'(err1), 0);
        chk("tol0.locked", 32'(locked0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
